// File: rtl/fft_pkg.sv
// Shared types for the inverse-FFT datapath: packed complex words and Q1.15 twiddle constants.
// No logic; latency and backpressure are properties of the modules that import this.
// Real half lives in the upper bits, imaginary half in the lower bits.
package fft_pkg;

    localparam int WIDTH = 32;
    localparam int HALF  = WIDTH / 2;

    localparam logic signed [HALF-1:0] ONE     = 16'sh7FFF;
    localparam logic signed [HALF-1:0] NEG_ONE = 16'sh8000;

    typedef struct packed {
        logic signed [HALF-1:0] re;
        logic signed [HALF-1:0] im;
    } cplx_t;

    function automatic cplx_t unpack_cplx(input logic [WIDTH-1:0] word);
        return cplx_t'(word);
    endfunction

    function automatic logic [WIDTH-1:0] pack_cplx(input cplx_t c);
        return WIDTH'(c);
    endfunction

endpackage

// File: rtl/cmul_conj.sv
// conj(w)*d in Q1.15, truncated back to HALF bits per component, with a wrap flag.
// Purely combinational, zero latency.
// No handshake; the enclosing pipeline owns flow control.
module cmul_conj
    import fft_pkg::*;
(
    input  cplx_t w,
    input  cplx_t d,
    output cplx_t b,
    output logic  ovf
);

    logic signed [WIDTH-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [WIDTH:0]   s_re, s_im;
    logic                    ovf_re, ovf_im;
    logic                    unused_lsb;

    always_comb begin
        p_rr = WIDTH'(w.re) * WIDTH'(d.re);
        p_ii = WIDTH'(w.im) * WIDTH'(d.im);
        p_ri = WIDTH'(w.re) * WIDTH'(d.im);
        p_ir = WIDTH'(w.im) * WIDTH'(d.re);
        s_re = (WIDTH+1)'(p_rr) + (WIDTH+1)'(p_ii);
        s_im = (WIDTH+1)'(p_ri) - (WIDTH+1)'(p_ir);
        b.re = s_re[WIDTH-2:HALF-1];
        b.im = s_im[WIDTH-2:HALF-1];
        // Top three bits must agree for the kept window to hold the true value.
        ovf_re = !((&s_re[WIDTH:WIDTH-2]) || !(|s_re[WIDTH:WIDTH-2]));
        ovf_im = !((&s_im[WIDTH:WIDTH-2]) || !(|s_im[WIDTH:WIDTH-2]));
        ovf    = ovf_re || ovf_im;
    end

    assign unused_lsb = ^{s_re[HALF-2:0], s_im[HALF-2:0]};

endmodule

// File: rtl/inverse_butterfly_unit.sv
// Radix-2 inverse butterfly: A = (X+Y)/2, B = conj(W)*(X-Y)/2, packed complex in and out.
// Latency 3 registered stages, counting the accepting edge; one beat per cycle.
// Single global stall: every stage holds while the output is valid and not taken; in_ready mirrors it.
module inverse_butterfly_unit
    import fft_pkg::*;
#(
    parameter int WIDTH = fft_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] W,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             ovf
);

    cplx_t             x_c, y_c, w_c, a_c, d_c;
    logic signed [HALF:0] s_re, s_im, t_re, t_im;
    logic              unused_lsb;
    logic              advance;

    logic              v1, v2;
    cplx_t             a1, d1, w1;
    cplx_t             a2, b2, b_c;
    logic              ovf2, ovf_c;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        x_c  = unpack_cplx(X);
        y_c  = unpack_cplx(Y);
        w_c  = unpack_cplx(W);
        s_re = (HALF+1)'(x_c.re) + (HALF+1)'(y_c.re);
        s_im = (HALF+1)'(x_c.im) + (HALF+1)'(y_c.im);
        t_re = (HALF+1)'(x_c.re) - (HALF+1)'(y_c.re);
        t_im = (HALF+1)'(x_c.im) - (HALF+1)'(y_c.im);
        // Dropping the LSB of the H+1 bit result is an arithmetic shift (floor) that always fits.
        a_c.re = s_re[HALF:1];
        a_c.im = s_im[HALF:1];
        d_c.re = t_re[HALF:1];
        d_c.im = t_im[HALF:1];
    end

    assign unused_lsb = s_re[0] ^ s_im[0] ^ t_re[0] ^ t_im[0];

    cmul_conj u_cmul (
        .w   (w1),
        .d   (d1),
        .b   (b_c),
        .ovf (ovf_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            a1        <= '0;
            d1        <= '0;
            w1        <= '0;
            a2        <= '0;
            b2        <= '0;
            ovf2      <= 1'b0;
            A         <= '0;
            B         <= '0;
            ovf       <= 1'b0;
        end else if (advance) begin
            v1 <= in_valid;
            if (in_valid) begin
                a1 <= a_c;
                d1 <= d_c;
                w1 <= w_c;
            end
            v2        <= v1;
            a2        <= a1;
            b2        <= b_c;
            ovf2      <= ovf_c;
            out_valid <= v2;
            A         <= pack_cplx(a2);
            B         <= pack_cplx(b2);
            ovf       <= ovf2;
        end
    end

endmodule

// File: tb/tb_inverse_butterfly_unit.sv
// Directed bench for inverse_butterfly_unit: hand-computed vectors, stall, reset flush, round-trip.
module tb_inverse_butterfly_unit;
    import fft_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, ovf;
    logic [31:0] X, Y, W, A, B;

    int          checks = 0;
    int          failures = 0;
    logic [64:0] exp_q[$];
    logic [64:0] cur_exp;
    bit          track, last_acc;
    int          emitted;

    logic [31:0] sx [4];
    logic [31:0] sa [4];
    logic [31:0] sb [4];
    int          rt_ar [3], rt_ai [3], rt_br [3], rt_bi [3], rt_wr [3], rt_wi [3];

    inverse_butterfly_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .W         (W),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A         (A),
        .B         (B),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] w, input logic [64:0] e);
        in_valid = v;
        X        = x;
        Y        = y;
        W        = w;
        cur_exp  = e;
    endtask

    // One clock: evaluate both handshakes just before the edge, then settle 1ns past it.
    task automatic step();
        #1;
        last_acc = in_valid && in_ready;
        if (track && last_acc) exp_q.push_back(cur_exp);
        if (track && out_valid && out_ready) begin
            emitted++;
            if (exp_q.size() == 0) chk("spurious_out_valid", 65'(out_valid), 65'd0);
            else chk("beat", {A, B, ovf}, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 12 && exp_q.size() != 0; i++) step();
        chk({"drain_", tag}, 65'(exp_q.size()), 65'd0);
    endtask

    task automatic latency3(input string tag);
        chk({tag, "_edge1"}, 65'(out_valid), 65'd0);
        step();
        chk({tag, "_edge2"}, 65'(out_valid), 65'd0);
        step();
        chk({tag, "_edge3"}, 65'(out_valid), 65'd1);
    endtask

    initial begin
        int   k, stall;
        bit   seen;
        int   pr, pi;
        real  mag, dr, di;

        for (int i = 0; i < 4; i++) begin
            sx[i] = {16'(i * 32'h400 + 32'h400), 16'h0200};
            sa[i] = {16'(i * 32'h200 + 32'h200), 16'h0100};
            sb[i] = {16'(i * 32'h200 + 32'h1FF), 16'h00FF};
        end
        rt_ar = '{1000, -4000, 0};     rt_ai = '{-2000, 1234, 3000};
        rt_br = '{3000, -2500, 1500};  rt_bi = '{500, 4000, -3500};
        rt_wr = '{23170, 32767, -16384}; rt_wi = '{23170, 0, 28378};

        rst = 1'b1; in_valid = 1'b0; X = '0; Y = '0; W = '0; out_ready = 1'b1;
        track = 1'b0; cur_exp = '0; emitted = 0; last_acc = 1'b0;
        @(posedge clk); #1;
        step();
        rst = 1'b0;
        chk("rst_out_valid", 65'(out_valid), 65'd0);
        chk("rst_A", 65'(A), 65'd0);
        chk("rst_B", 65'(B), 65'd0);
        chk("rst_ovf", 65'(ovf), 65'd0);
        chk("rst_in_ready", 65'(in_ready), 65'd1);

        // W = +1: B is D scaled by 0x7FFF/0x8000, truncated.
        track = 1'b1;
        drive(1'b1, 32'h4000_0000, 32'h0, {ONE, 16'h0}, {32'h2000_0000, 32'h1FFF_0000, 1'b0});
        step();
        in_valid = 1'b0;
        latency3("lat");
        drain("t1");

        // W = -j then the +2^31 wrap case, back to back.
        drive(1'b1, 32'h4000_0000, 32'h0, {16'h0, NEG_ONE}, {32'h2000_0000, 32'h0000_2000, 1'b0});
        step();
        drive(1'b1, 32'h8000_8000, 32'h7FFF_7FFF, {NEG_ONE, NEG_ONE}, {32'hFFFF_FFFF, 32'h0, 1'b1});
        step();
        in_valid = 1'b0;
        drain("t23");

        // Four-beat stream with a five-cycle downstream stall starting at the first output.
        emitted = 0; k = 0; seen = 1'b0; stall = 0;
        for (int cyc = 0; cyc < 40 && (k < 4 || exp_q.size() != 0); cyc++) begin
            if (k < 4) drive(1'b1, sx[k], 32'h0, {ONE, 16'h0}, {sa[k], sb[k], 1'b0});
            else in_valid = 1'b0;
            if (out_valid) seen = 1'b1;
            out_ready = !(seen && stall < 5);
            if (!out_ready) begin
                stall++;
                #1;
                chk("stall_in_ready", 65'(in_ready), 65'd0);
                chk("stall_hold", {A, B, ovf}, exp_q[0]);
                if (stall == 1) chk("stall_accepted", 65'(k), 65'd3);
            end
            step();
            if (last_acc) k++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stall_emitted", 65'(emitted), 65'd4);
        chk("stall_drain", 65'(exp_q.size()), 65'd0);

        // Reset with three beats in flight (output stalled so none is handed off).
        track = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, sx[i], 32'h0, {ONE, 16'h0}, 65'd0);
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_out_valid", 65'(out_valid), 65'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("flush_out_valid", 65'(out_valid), 65'd0);
        chk("flush_A", 65'(A), 65'd0);
        chk("flush_B", 65'(B), 65'd0);
        chk("flush_ovf", 65'(ovf), 65'd0);
        chk("flush_in_ready", 65'(in_ready), 65'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("flush_quiet", 65'(out_valid), 65'd0);
        end
        exp_q.delete();
        track = 1'b1;
        drive(1'b1, 32'h4000_0000, 32'h0, {ONE, 16'h0}, {32'h2000_0000, 32'h1FFF_0000, 1'b0});
        step();
        in_valid = 1'b0;
        latency3("post_rst_lat");
        drain("post_rst");

        // Round trip through a forward butterfly built here from (A, B, W).
        track = 1'b0;
        for (int t = 0; t < 3; t++) begin
            pr = (rt_wr[t] * rt_br[t] - rt_wi[t] * rt_bi[t] + 16384) >>> 15;
            pi = (rt_wr[t] * rt_bi[t] + rt_wi[t] * rt_br[t] + 16384) >>> 15;
            drive(1'b1, {16'(rt_ar[t] + pr), 16'(rt_ai[t] + pi)},
                  {16'(rt_ar[t] - pr), 16'(rt_ai[t] - pi)},
                  {16'(rt_wr[t]), 16'(rt_wi[t])}, 65'd0);
            step();
            in_valid = 1'b0;
            for (int i = 0; i < 8 && !out_valid; i++) step();
            chk("rt_out_valid", 65'(out_valid), 65'd1);
            chk("rt_A", 65'(A), 65'({16'(rt_ar[t]), 16'(rt_ai[t])}));
            chk("rt_ovf", 65'(ovf), 65'd0);
            mag = $itor(rt_wr[t] * rt_wr[t] + rt_wi[t] * rt_wi[t]) / 1073741824.0;
            dr  = $itor($signed(B[31:16])) - mag * $itor(rt_br[t]);
            di  = $itor($signed(B[15:0]))  - mag * $itor(rt_bi[t]);
            checks++;
            assert (dr <= 2.0 && dr >= -2.0 && di <= 2.0 && di >= -2.0) else begin
                failures++;
                $error("FAIL rt_B observed=%h expected_re=%f expected_im=%f", B,
                       mag * $itor(rt_br[t]), mag * $itor(rt_bi[t]));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
